// File: rtl/product_accumulator_if.sv
// Product-in / group-sum-out handshake bundle for product_accumulator.
// Each side follows valid/ready: a beat transfers on a rising edge where valid & ready are both 1.
interface product_accumulator_if #(
  parameter int PROD_W = 12,
  parameter int ACC_W  = 16
);
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_sat;
  logic              busy;
  logic              state_dbg;

  modport master (
    output clear, in_valid, in_product, out_ready,
    input  in_ready, out_valid, out_sum, out_sat, busy, state_dbg
  );

  modport slave (
    input  clear, in_valid, in_product, out_ready,
    output in_ready, out_valid, out_sum, out_sat, busy, state_dbg
  );
endinterface

// File: rtl/product_accumulator.sv
// Sums groups of COUNT signed products into a saturating accumulator and
// presents each group total on a valid/ready output; one group in flight at a time.
module product_accumulator #(
  parameter int PROD_W = 12,
  parameter int ACC_W  = 16,
  parameter int COUNT  = 4
) (
  input  logic clk,
  input  logic rst,
  product_accumulator_if.slave bus
);
  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

  state_t                   state_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     sat_q;
  logic                     out_valid_q;
  logic [ACC_W-1:0]         out_sum_q;
  logic                     out_sat_q;

  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W:0]    sum_wide;
  logic                     clamp_hi;
  logic                     clamp_lo;
  logic                     clamp_d;
  logic signed [ACC_W-1:0]  acc_d;
  logic                     accept;

  // One guard bit is enough: two ACC_W-bit signed operands cannot overflow ACC_W+1 bits.
  assign prod_ext = ACC_W'($signed(bus.in_product));
  assign sum_wide = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod_ext);
  assign clamp_hi = !sum_wide[ACC_W] &&  sum_wide[ACC_W-1];
  assign clamp_lo =  sum_wide[ACC_W] && !sum_wide[ACC_W-1];
  assign clamp_d  = clamp_hi | clamp_lo;

  always_comb begin
    acc_d = sum_wide[ACC_W-1:0];
    if (clamp_hi) acc_d = ACC_MAX;
    if (clamp_lo) acc_d = ACC_MIN;
  end

  assign accept = bus.in_valid && (state_q == ACCUM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_sat_q   <= 1'b0;
    end else if (bus.clear) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            if (cnt_q == LAST_CNT) begin
              out_sum_q   <= acc_d;
              out_sat_q   <= sat_q | clamp_d;
              out_valid_q <= 1'b1;
              acc_q       <= '0;
              cnt_q       <= '0;
              sat_q       <= 1'b0;
              state_q     <= DONE;
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_q + 1'b1;
              sat_q <= sat_q | clamp_d;
            end
          end
        end
        DONE: begin
          // Result holds until the consumer takes it; no input overlap on the handshake cycle.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.busy      = (cnt_q != '0) | out_valid_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a 16-bit accumulator instance for the
// general cases and a 12-bit instance for the saturation cases.
module tb_product_accumulator;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  product_accumulator_if #(.PROD_W(12), .ACC_W(16)) bus16 ();
  product_accumulator_if #(.PROD_W(12), .ACC_W(12)) bus12 ();

  product_accumulator #(.PROD_W(12), .ACC_W(16), .COUNT(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  product_accumulator #(.PROD_W(12), .ACC_W(12), .COUNT(4)) dut12 (
    .clk (clk),
    .rst (rst),
    .bus (bus12.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic send16(input int p);
    int t;
    t = 0;
    bus16.in_valid   = 1'b1;
    bus16.in_product = 12'(p);
    while (!bus16.in_ready && t < 20) begin
      tick();
      t++;
    end
    checks++;
    if (t >= 20) begin
      errors++;
      $display("FAIL send16_timeout: in_ready=%0b after %0d cycles, required 1", bus16.in_ready, t);
    end
    tick();
    bus16.in_valid   = 1'b0;
    bus16.in_product = 'x;
  endtask

  task automatic send12(input int p);
    int t;
    t = 0;
    bus12.in_valid   = 1'b1;
    bus12.in_product = 12'(p);
    while (!bus12.in_ready && t < 20) begin
      tick();
      t++;
    end
    checks++;
    if (t >= 20) begin
      errors++;
      $display("FAIL send12_timeout: in_ready=%0b after %0d cycles, required 1", bus12.in_ready, t);
    end
    tick();
    bus12.in_valid   = 1'b0;
    bus12.in_product = 'x;
  endtask

  task automatic release16();
    bus16.out_ready = 1'b1;
    tick();
    bus16.out_ready = 1'b0;
  endtask

  task automatic release12();
    bus12.out_ready = 1'b1;
    tick();
    bus12.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (bus16.out_valid !== 1'b0 || bus16.busy !== 1'b0 || bus16.out_sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: out_valid=%0b busy=%0b out_sat=%0b, required 0 0 0",
               bus16.out_valid, bus16.busy, bus16.out_sat);
    end
    checks++;
    if (bus16.out_sum !== 16'd0 || bus16.in_ready !== 1'b1 || bus16.state_dbg !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: out_sum=%0d in_ready=%0b state=%0b, required 0 1 0",
               bus16.out_sum, bus16.in_ready, bus16.state_dbg);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_group();
    send16(91);
    send16(-12);
    send16(66);
    checks++;
    if (bus16.out_valid !== 1'b0 || bus16.busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_partial: out_valid=%0b busy=%0b, required 0 1", bus16.out_valid, bus16.busy);
    end
    send16(0);
    checks++;
    if (bus16.out_valid !== 1'b1 || bus16.out_sum !== 16'd145 || bus16.out_sat !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: out_valid=%0b out_sum=%0d out_sat=%0b, required 1 145 0",
               bus16.out_valid, $signed(bus16.out_sum), bus16.out_sat);
    end
    checks++;
    if (bus16.in_ready !== 1'b0 || bus16.busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_done_flags: in_ready=%0b busy=%0b, required 0 1", bus16.in_ready, bus16.busy);
    end
    release16();
    checks++;
    if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1 || bus16.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_release: out_valid=%0b in_ready=%0b busy=%0b, required 0 1 0",
               bus16.out_valid, bus16.in_ready, bus16.busy);
    end
  endtask

  task automatic test_backpressure();
    send16(91);
    send16(-12);
    send16(66);
    send16(0);
    bus16.in_valid   = 1'b1;
    bus16.in_product = 12'd500;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus16.out_valid !== 1'b1 || bus16.out_sum !== 16'd145 || bus16.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: out_valid=%0b out_sum=%0d in_ready=%0b, required 1 145 0",
                 i, bus16.out_valid, $signed(bus16.out_sum), bus16.in_ready);
      end
    end
    // in_valid stays high through the handshake; the 500 must only land after it.
    bus16.out_ready = 1'b1;
    tick();
    bus16.out_ready = 1'b0;
    checks++;
    if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1 || bus16.busy !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: out_valid=%0b in_ready=%0b busy=%0b, required 0 1 0",
               bus16.out_valid, bus16.in_ready, bus16.busy);
    end
    tick();
    bus16.in_valid   = 1'b0;
    bus16.in_product = 'x;
    send16(1);
    send16(2);
    checks++;
    if (bus16.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_early_result: out_valid=%0b, required 0", bus16.out_valid);
    end
    send16(3);
    checks++;
    if (bus16.out_valid !== 1'b1 || bus16.out_sum !== 16'd506) begin
      errors++;
      $display("FAIL backpressure_next_group: out_valid=%0b out_sum=%0d, required 1 506",
               bus16.out_valid, $signed(bus16.out_sum));
    end
    release16();
  endtask

  task automatic test_gaps();
    send16(3);
    for (int i = 0; i < 3; i++) tick();
    send16(5);
    tick();
    send16(-7);
    checks++;
    if (bus16.out_valid !== 1'b0 || bus16.busy !== 1'b1) begin
      errors++;
      $display("FAIL gaps_partial: out_valid=%0b busy=%0b, required 0 1", bus16.out_valid, bus16.busy);
    end
    send16(2);
    checks++;
    if (bus16.out_valid !== 1'b1 || bus16.out_sum !== 16'd3 || bus16.out_sat !== 1'b0) begin
      errors++;
      $display("FAIL gaps_result: out_valid=%0b out_sum=%0d out_sat=%0b, required 1 3 0",
               bus16.out_valid, $signed(bus16.out_sum), bus16.out_sat);
    end
    release16();
  endtask

  task automatic test_clear();
    send16(20);
    send16(30);
    bus16.clear      = 1'b1;
    bus16.in_valid   = 1'b1;
    bus16.in_product = 12'd100;
    tick();
    bus16.clear      = 1'b0;
    bus16.in_valid   = 1'b0;
    bus16.in_product = 'x;
    checks++;
    if (bus16.busy !== 1'b0 || bus16.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_mid_group: busy=%0b out_valid=%0b, required 0 0", bus16.busy, bus16.out_valid);
    end
    send16(1);
    send16(1);
    send16(1);
    checks++;
    if (bus16.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_early_result: out_valid=%0b, required 0", bus16.out_valid);
    end
    send16(1);
    checks++;
    if (bus16.out_valid !== 1'b1 || bus16.out_sum !== 16'd4) begin
      errors++;
      $display("FAIL clear_result: out_valid=%0b out_sum=%0d, required 1 4",
               bus16.out_valid, $signed(bus16.out_sum));
    end
    bus16.clear = 1'b1;
    tick();
    bus16.clear = 1'b0;
    checks++;
    if (bus16.out_valid !== 1'b0 || bus16.out_sum !== 16'd0 || bus16.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_in_done: out_valid=%0b out_sum=%0d in_ready=%0b, required 0 0 1",
               bus16.out_valid, $signed(bus16.out_sum), bus16.in_ready);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) send12(1024);
    checks++;
    if (bus12.out_valid !== 1'b1 || bus12.out_sum !== 12'h7FF || bus12.out_sat !== 1'b1) begin
      errors++;
      $display("FAIL sat_positive: out_valid=%0b out_sum=%0d out_sat=%0b, required 1 2047 1",
               bus12.out_valid, $signed(bus12.out_sum), bus12.out_sat);
    end
    release12();
    for (int i = 0; i < 4; i++) send12(-992);
    checks++;
    if (bus12.out_valid !== 1'b1 || bus12.out_sum !== 12'h800 || bus12.out_sat !== 1'b1) begin
      errors++;
      $display("FAIL sat_negative: out_valid=%0b out_sum=%0d out_sat=%0b, required 1 -2048 1",
               bus12.out_valid, $signed(bus12.out_sum), bus12.out_sat);
    end
    release12();
    // Sticky flag must not leak into the following group.
    for (int i = 0; i < 4; i++) send12(100);
    checks++;
    if (bus12.out_sum !== 12'd400 || bus12.out_sat !== 1'b0) begin
      errors++;
      $display("FAIL sat_cleared: out_sum=%0d out_sat=%0b, required 400 0",
               $signed(bus12.out_sum), bus12.out_sat);
    end
    release12();
  endtask

  task automatic test_rst_in_done();
    send16(91);
    send16(-12);
    send16(66);
    send16(0);
    checks++;
    if (bus16.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_setup: out_valid=%0b, required 1", bus16.out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus16.out_valid !== 1'b0 || bus16.busy !== 1'b0 || bus16.out_sum !== 16'd0) begin
      errors++;
      $display("FAIL rst_async: out_valid=%0b busy=%0b out_sum=%0d, required 0 0 0",
               bus16.out_valid, bus16.busy, $signed(bus16.out_sum));
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus16.in_ready !== 1'b1 || bus16.out_valid !== 1'b0 || bus16.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_release: in_ready=%0b out_valid=%0b busy=%0b, required 1 0 0",
               bus16.in_ready, bus16.out_valid, bus16.busy);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus16.clear = 1'b0; bus16.in_valid = 1'b0; bus16.in_product = 'x; bus16.out_ready = 1'b0;
    bus12.clear = 1'b0; bus12.in_valid = 1'b0; bus12.in_product = 'x; bus12.out_ready = 1'b0;
    #2;
    test_reset();
    test_basic_group();
    test_backpressure();
    test_gaps();
    test_clear();
    test_saturation();
    test_rst_in_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
